// File: rtl/demux_pkg.sv
// Shared definitions for the routing library: slot-count helpers and one-hot select decode.
// Select widths up to MAX_SIZE_CTRL bits are supported by onehot().
package demux_pkg;

    localparam int MAX_SIZE_CTRL = 8;
    localparam int MAX_SLOTS     = 2**MAX_SIZE_CTRL;
    localparam int DEF_SIZE_CTRL = 2;
    localparam int SLOTS         = 2**DEF_SIZE_CTRL;

    // Callers size-cast the result down to their own 2**SIZE_CTRL slots.
    function automatic logic [MAX_SLOTS-1:0] onehot(input logic [MAX_SIZE_CTRL-1:0] ctrl);
        logic [MAX_SLOTS-1:0] v;
        v       = '0;
        v[ctrl] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/demux_slot.sv
// One output lane register of the demux: load has priority over clear.
// Latency: 1 clk. Backpressure: none; holds when neither load nor clear is set.
module demux_slot #(
    parameter int WIRE = 8
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            clear,
    input  logic [WIRE-1:0] d,
    output logic [WIRE-1:0] q
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)        q <= '0;
        else if (load)  q <= d;
        else if (clear) q <= '0;
    end

endmodule

// File: rtl/demux.sv
// Registered 1-to-2**SIZE_CTRL demux; DEMUX_HOLD_EN keeps unselected slots instead of zeroing them.
// Latency: 1 clk from en/ctrl/in to out/out_sel. Backpressure: en=0 holds all outputs.
module demux
    import demux_pkg::*;
#(
    parameter int SIZE_CTRL = 2,
    parameter int WIRE      = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [SIZE_CTRL-1:0]          ctrl,
    input  logic [WIRE-1:0]               in,
    output logic [(2**SIZE_CTRL)*WIRE-1:0] out,
    output logic [(2**SIZE_CTRL)-1:0]      out_sel
);

    localparam int N = 2**SIZE_CTRL;

    logic [N-1:0]    sel;
    logic [WIRE-1:0] slot_q [N];

    assign sel = N'(onehot(MAX_SIZE_CTRL'(ctrl)));

    for (genvar k = 0; k < N; k++) begin : g_slot
        logic clear;
`ifdef DEMUX_HOLD_EN
        assign clear = 1'b0;
`else
        assign clear = en & ~sel[k];
`endif
        demux_slot #(.WIRE(WIRE)) u_slot (
            .clk   (clk),
            .rst   (rst),
            .load  (en & sel[k]),
            .clear (clear),
            .d     (in),
            .q     (slot_q[k])
        );
        assign out[k*WIRE +: WIRE] = slot_q[k];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst)     out_sel <= '0;
        else if (en) out_sel <= sel;
    end

endmodule

// File: tb/tb_demux.sv
// Directed bench for demux: default 2/8 instance plus a SIZE_CTRL=1, WIRE=1 corner instance.
module tb_demux;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        en = 1'b0;
    logic [1:0]  ctrl = '0;
    logic [7:0]  in = '0;
    logic [31:0] out;
    logic [3:0]  out_sel;

    logic        c_en = 1'b0;
    logic        c_ctrl = 1'b0;
    logic        c_in = 1'b0;
    logic [1:0]  c_out;
    logic [1:0]  c_sel;

    int n_vec  = 0;
    int n_miss = 0;

    always #5 clk = ~clk;

    demux #(.SIZE_CTRL(2), .WIRE(8)) dut (
        .clk(clk), .rst(rst), .en(en), .ctrl(ctrl), .in(in),
        .out(out), .out_sel(out_sel)
    );

    demux #(.SIZE_CTRL(1), .WIRE(1)) dut_c (
        .clk(clk), .rst(rst), .en(c_en), .ctrl(c_ctrl), .in(c_in),
        .out(c_out), .out_sel(c_sel)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h want %h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Pulse reset between edges (called just after an edge).
    task automatic pulse_rst();
        #1 rst = 1'b1;
        #2 rst = 1'b0;
    endtask

    logic [31:0] sweep_out [4] = '{32'h0000_00AA, 32'h0000_AA00, 32'h00AA_0000, 32'hAA00_0000};
    logic [3:0]  sweep_sel [4] = '{4'b0001, 4'b0010, 4'b0100, 4'b1000};

    initial begin
        // Async reset before any clock edge.
        #2 rst = 1'b1;
        #1;
        chk("rst_out", 64'(out), 64'h0);
        chk("rst_sel", 64'(out_sel), 64'h0);
        chk("rst_c_out", 64'(c_out), 64'h0);
        chk("rst_c_sel", 64'(c_sel), 64'h0);
        tick();
        rst = 1'b0;

        // Sweep every slot from a clean state.
        for (int c = 0; c < 4; c++) begin
            pulse_rst();
            en = 1'b1; in = 8'hAA; ctrl = 2'(c);
            tick();
            chk($sformatf("sweep_out%0d", c), 64'(out), 64'(sweep_out[c]));
            chk($sformatf("sweep_sel%0d", c), 64'(out_sel), 64'(sweep_sel[c]));
        end

        // Hold with en=0.
        pulse_rst();
        en = 1'b1; ctrl = 2'd2; in = 8'hAA;
        tick();
        en = 1'b0; ctrl = 2'd0; in = 8'h55;
        tick();
        tick();
        chk("hold_out", 64'(out), 64'h00AA_0000);
        chk("hold_sel", 64'(out_sel), 64'b0100);

        // Back-to-back captures to different slots.
        pulse_rst();
        en = 1'b1; ctrl = 2'd1; in = 8'h11;
        tick();
        chk("b2b_out1", 64'(out), 64'h0000_1100);
        chk("b2b_sel1", 64'(out_sel), 64'b0010);
        ctrl = 2'd3; in = 8'h22;
        tick();
`ifdef DEMUX_HOLD_EN
        chk("b2b_out2", 64'(out), 64'h2200_1100);
`else
        chk("b2b_out2", 64'(out), 64'h2200_0000);
`endif
        chk("b2b_sel2", 64'(out_sel), 64'b1000);

        // Mid-stream reset discards state; next enabled edge captures normally.
        pulse_rst();
        en = 1'b1; ctrl = 2'd3; in = 8'hAA;
        tick();
        chk("mid_pre", 64'(out), 64'hAA00_0000);
        ctrl = 2'd0;
        #1 rst = 1'b1;
        #1;
        chk("mid_rst_out", 64'(out), 64'h0);
        chk("mid_rst_sel", 64'(out_sel), 64'h0);
        rst = 1'b0;
        tick();
        chk("mid_post_out", 64'(out), 64'h0000_00AA);
        chk("mid_post_sel", 64'(out_sel), 64'b0001);
        en = 1'b0;

        // Parameter corner: SIZE_CTRL=1, WIRE=1.
        pulse_rst();
        c_en = 1'b1; c_ctrl = 1'b1; c_in = 1'b1;
        tick();
        chk("corner_out1", 64'(c_out), 64'b10);
        chk("corner_sel1", 64'(c_sel), 64'b10);
        c_ctrl = 1'b0;
        tick();
`ifdef DEMUX_HOLD_EN
        chk("corner_out0", 64'(c_out), 64'b11);
`else
        chk("corner_out0", 64'(c_out), 64'b01);
`endif
        chk("corner_sel0", 64'(c_sel), 64'b01);
        c_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule
